// File: rtl/imem_loader.sv
// Streams bytes into 32-bit big-endian words and writes them to instruction memory.
// One write per word, issued the cycle after its 4th byte is accepted; busy holds the CPU in reset.
module imem_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [10:0] num_words,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, FIN} state_t;

  localparam logic [10:0] DEPTH_NW = 11'(DEPTH);

  state_t            state_q, state_d;
  logic [10:0]       num_words_q, num_words_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              error_q, error_d;
  logic              start_legal;
  logic              last_word;

  assign start_legal = (num_words != 11'd0) && (num_words <= DEPTH_NW);
  assign last_word   = (11'(word_idx_q) == (num_words_q - 11'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      num_words_q <= '0;
      word_idx_q  <= '0;
      byte_cnt_q  <= '0;
      asm_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_words_q <= num_words_d;
      word_idx_q  <= word_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    num_words_d = num_words_q;
    word_idx_d  = word_idx_q;
    byte_cnt_d  = byte_cnt_q;
    asm_d       = asm_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    error_d     = error_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (start_legal) begin
            num_words_d = num_words;
            word_idx_d  = '0;
            byte_cnt_d  = '0;
            error_d     = 1'b0;
            state_d     = RECV;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      RECV: begin
        if (byte_valid) begin
          asm_d      = {asm_q[23:0], byte_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Address and data are registered here so they hold after word_idx advances.
          if (byte_cnt_q == 2'd3) begin
            mem_addr_d  = {{(30-ADDR_W){1'b0}}, word_idx_q, 2'b00};
            mem_wdata_d = {asm_q[23:0], byte_data};
            state_d     = WRITE;
          end
        end
      end
      WRITE: begin
        if (last_word) begin
          state_d = FIN;
        end else begin
          word_idx_d = word_idx_q + ADDR_W'(1);
          byte_cnt_d = '0;
          state_d    = RECV;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign byte_ready = (state_q == RECV);
  assign mem_we     = (state_q == WRITE);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FIN);
  assign error      = error_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_imem_loader;

  typedef struct packed {
    logic        we;
    logic        rdy;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] addr;
    logic [31:0] wdata;
  } out_t;

  typedef struct {
    logic        start;
    logic [10:0] nw;
    logic        bv;
    logic [7:0]  bd;
    out_t        exp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [10:0] num_words;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int done_cnt = 0;

  imem_loader #(.DEPTH(1024), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (mem_we) we_cnt++;
    if (done) done_cnt++;
  end

  function automatic out_t obs();
    out_t o;
    o.we = mem_we; o.rdy = byte_ready; o.busy = busy; o.done = done; o.err = error;
    o.addr = mem_addr; o.wdata = mem_wdata;
    return o;
  endfunction

  function automatic out_t mk(input logic we, input logic rdy, input logic bsy, input logic dn,
                              input logic er, input logic [31:0] a, input logic [31:0] d);
    out_t o;
    o.we = we; o.rdy = rdy; o.busy = bsy; o.done = dn; o.err = er; o.addr = a; o.wdata = d;
    return o;
  endfunction

  function automatic vec_t v(input logic st, input logic [10:0] nw, input logic bv,
                             input logic [7:0] bd, input out_t e);
    vec_t r;
    r.start = st; r.nw = nw; r.bv = bv; r.bd = bd; r.exp = e;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [10:0] nw, input logic bv, input logic [7:0] bd);
    start = st; num_words = nw; byte_valid = bv; byte_data = bd;
    @(posedge clk);
    #1;
    start = 1'b0; byte_valid = 1'b0;
  endtask

  // Sends four bytes of w, checks the resulting write, then spends the WRITE cycle idle.
  task automatic send_word(input string nm, input logic [31:0] w, input logic [31:0] a);
    for (int b = 0; b < 4; b++) begin
      drive(1'b0, 11'd0, 1'b1, w[31-8*b -: 8]);
    end
    chk(nm, 69'({mem_we, mem_addr, mem_wdata}), 69'({1'b1, a, w}));
    drive(1'b0, 11'd0, 1'b0, 8'h00);
  endtask

  vec_t vecs[22];

  initial begin
    int we0;
    int dn0;
    logic [31:0] w;
    rst_n = 1'b0; start = 1'b0; num_words = '0; byte_valid = 1'b0; byte_data = '0;

    vecs[0]  = v(1, 11'd2,    0, 8'h00, mk(0,1,1,0,0, 32'h0, 32'h0));
    vecs[1]  = v(0, 11'd0,    1, 8'h20, mk(0,1,1,0,0, 32'h0, 32'h0));
    vecs[2]  = v(0, 11'd0,    1, 8'h08, mk(0,1,1,0,0, 32'h0, 32'h0));
    vecs[3]  = v(0, 11'd0,    1, 8'h00, mk(0,1,1,0,0, 32'h0, 32'h0));
    vecs[4]  = v(0, 11'd0,    1, 8'h05, mk(1,0,1,0,0, 32'h0, 32'h20080005));
    vecs[5]  = v(0, 11'd0,    1, 8'hFF, mk(0,1,1,0,0, 32'h0, 32'h20080005));
    vecs[6]  = v(0, 11'd0,    1, 8'h24, mk(0,1,1,0,0, 32'h0, 32'h20080005));
    vecs[7]  = v(0, 11'd0,    1, 8'h09, mk(0,1,1,0,0, 32'h0, 32'h20080005));
    vecs[8]  = v(0, 11'd0,    1, 8'h00, mk(0,1,1,0,0, 32'h0, 32'h20080005));
    vecs[9]  = v(0, 11'd0,    1, 8'h07, mk(1,0,1,0,0, 32'h4, 32'h24090007));
    vecs[10] = v(0, 11'd0,    0, 8'h00, mk(0,0,1,1,0, 32'h4, 32'h24090007));
    vecs[11] = v(0, 11'd0,    0, 8'h00, mk(0,0,0,0,0, 32'h4, 32'h24090007));
    vecs[12] = v(1, 11'd0,    0, 8'h00, mk(0,0,0,0,1, 32'h4, 32'h24090007));
    vecs[13] = v(0, 11'd0,    0, 8'h00, mk(0,0,0,0,1, 32'h4, 32'h24090007));
    vecs[14] = v(1, 11'd1025, 0, 8'h00, mk(0,0,0,0,1, 32'h4, 32'h24090007));
    vecs[15] = v(1, 11'd1,    0, 8'h00, mk(0,1,1,0,0, 32'h4, 32'h24090007));
    vecs[16] = v(1, 11'd5,    1, 8'hAA, mk(0,1,1,0,0, 32'h4, 32'h24090007));
    vecs[17] = v(0, 11'd0,    1, 8'hBB, mk(0,1,1,0,0, 32'h4, 32'h24090007));
    vecs[18] = v(0, 11'd0,    1, 8'hCC, mk(0,1,1,0,0, 32'h4, 32'h24090007));
    vecs[19] = v(0, 11'd0,    1, 8'hDD, mk(1,0,1,0,0, 32'h0, 32'hAABBCCDD));
    vecs[20] = v(1, 11'd3,    0, 8'h00, mk(0,0,1,1,0, 32'h0, 32'hAABBCCDD));
    vecs[21] = v(0, 11'd0,    0, 8'h00, mk(0,0,0,0,0, 32'h0, 32'hAABBCCDD));

    #22;
    chk("reset_state", 69'(obs()), 69'(out_t'('0)));
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].start, vecs[i].nw, vecs[i].bv, vecs[i].bd);
      chk($sformatf("vec%0d", i), 69'(obs()), 69'(vecs[i].exp));
    end

    // Stall with byte_valid low between bytes 2 and 3.
    we0 = we_cnt;
    drive(1'b1, 11'd1, 1'b0, 8'h00);
    drive(1'b0, 11'd0, 1'b1, 8'h11);
    drive(1'b0, 11'd0, 1'b1, 8'h22);
    for (int g = 0; g < 5; g++) begin
      drive(1'b0, 11'd0, 1'b0, 8'h99);
      chk($sformatf("gap%0d_rdy_we", g), 69'({byte_ready, mem_we}), 69'(2'b10));
    end
    drive(1'b0, 11'd0, 1'b1, 8'h33);
    drive(1'b0, 11'd0, 1'b1, 8'h44);
    chk("gap_write", 69'({mem_we, mem_addr, mem_wdata}), 69'({1'b1, 32'h0, 32'h11223344}));
    drive(1'b0, 11'd0, 1'b0, 8'h00);
    chk("gap_done", 69'({done, busy}), 69'(2'b11));
    drive(1'b0, 11'd0, 1'b0, 8'h00);
    chk("gap_wecount", 69'(we_cnt - we0), 69'(1));

    // Full-depth load with random data.
    we0 = we_cnt;
    dn0 = done_cnt;
    drive(1'b1, 11'd1024, 1'b0, 8'h00);
    for (int k = 0; k < 1024; k++) begin
      w = $urandom;
      send_word($sformatf("full_w%0d", k), w, 32'(k) << 2);
    end
    chk("full_last_addr", 69'(mem_addr), 69'(32'hFFC));
    chk("full_fin", 69'({done, busy}), 69'(2'b11));
    drive(1'b0, 11'd0, 1'b0, 8'h00);
    chk("full_idle", 69'(busy), 69'(0));
    chk("full_wecount", 69'(we_cnt - we0), 69'(1024));
    chk("full_donecount", 69'(done_cnt - dn0), 69'(1));

    // Reset in the middle of word 3.
    we0 = we_cnt;
    drive(1'b1, 11'd4, 1'b0, 8'h00);
    send_word("rst_w0", 32'h01010101, 32'h0);
    send_word("rst_w1", 32'h02020202, 32'h4);
    send_word("rst_w2", 32'h03030303, 32'h8);
    drive(1'b0, 11'd0, 1'b1, 8'hDE);
    drive(1'b0, 11'd0, 1'b1, 8'hAD);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", 69'(obs()), 69'(out_t'('0)));
    chk("rst_wecount", 69'(we_cnt - we0), 69'(3));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_hold_idle", 69'({mem_we, busy}), 69'(2'b00));
    drive(1'b1, 11'd1, 1'b0, 8'h00);
    send_word("rst_fresh", 32'hCAFEF00D, 32'h0);
    chk("rst_fresh_done", 69'(done), 69'(1));
    drive(1'b0, 11'd0, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: DEPTH, 1024, number of 32-bit words in the target instruction memory.
REQ-002 Parameter: ADDR_W, 10, word-index width, equal to log2(DEPTH).
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: start  input  1  one-cycle request to begin a load.
REQ-006 Port: num_words  input  11  number of words to load, sampled when start is accepted.
REQ-007 Port: byte_valid  input  1  byte_data carries a byte.
REQ-008 Port: byte_data  input  8  incoming program byte.
REQ-009 Port: byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 Port: mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-011 Port: mem_addr  output  32  byte address, word-aligned, bits[1:0]=0; the memory indexes words with bits[11:2].
REQ-012 Port: mem_wdata  output  32  assembled instruction word.
REQ-013 Port: busy  output  1  load in progress; holds the CPU in reset.
REQ-014 Port: done  output  1  one-cycle pulse when the final word is written.
REQ-015 Port: error  output  1  sticky flag set when num_words is illegal.

Function
REQ-016 The FSM SHALL have the states IDLE, RECV, WRITE and FIN.
REQ-017 In IDLE, start=1 with 1<=num_words<=DEPTH SHALL latch num_words, clear word_idx, byte_cnt and error, and move to RECV on the next edge.
REQ-018 In IDLE, start=1 with num_words=0 or num_words>DEPTH SHALL set error, stay in IDLE, and perform no write.
REQ-019 start SHALL be ignored in any state other than IDLE.
REQ-020 byte_ready SHALL be 1 only in RECV; a byte is accepted on an edge where byte_valid&&byte_ready.
REQ-021 Bytes SHALL assemble big-endian: the 1st accepted byte goes to [31:24], the 2nd to [23:16], the 3rd to [15:8] and the 4th to [7:0].
REQ-022 Acceptance of the 4th byte SHALL move the FSM to WRITE, so mem_we=1 in the cycle immediately after that acceptance (latency 1).
REQ-023 In WRITE, mem_we=1 for exactly one cycle, with mem_addr={20'b0, word_idx, 2'b00} and mem_wdata set to the assembled word.
REQ-024 From WRITE, if word_idx==num_words-1 the FSM SHALL go to FIN; otherwise word_idx increments, byte_cnt clears and the FSM returns to RECV.
REQ-025 FIN SHALL last one cycle with done=1, then return to IDLE.
REQ-026 busy SHALL be 1 in RECV, WRITE and FIN, and 0 in IDLE.
REQ-027 byte_valid gaps in RECV SHALL stall without timeout; partial-word state is held.
REQ-028 mem_we SHALL be 0 in every state except WRITE; mem_addr and mem_wdata hold their last values outside WRITE.
REQ-029 Loading DEPTH words SHALL write word index DEPTH-1 (byte address 0xFFC) last; word_idx never wraps within one load.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, with mem_we=0, byte_ready=0, busy=0, done=0, error=0, mem_addr=0, mem_wdata=0, word_idx=0 and byte_cnt=0.
REQ-031 Reset during RECV or WRITE SHALL discard any partial word; words already written are not retracted, and no further write occurs until a new start.

Verification
REQ-032 start with num_words=2, then bytes 20 08 00 05 24 09 00 07 streamed back-to-back -> mem_we pulses with addr 0x0/data 0x20080005 and addr 0x4/data 0x24090007; done pulses one cycle after the 2nd write; busy then drops.
REQ-033 num_words=1 with byte_valid deasserted for 5 cycles between the 2nd and 3rd bytes -> a single write of the correct word, and byte_ready stays high throughout the gap.
REQ-034 start with num_words=0, then separately with num_words=1025 -> error=1, busy=0, and no mem_we in either case; a following legal start clears error.
REQ-035 num_words=1024 with random bytes -> 1024 writes with strictly increasing addresses 0x000 to 0xFFC and exactly one done pulse.
REQ-036 rst_n pulsed low after 2 bytes of word 3 -> mem_we goes 0 immediately; a fresh start with num_words=1 writes address 0x0 using only the bytes sent after the new start.
REQ-037 start pulsed during RECV -> ignored, with num_words, word_idx and the write sequence unchanged.
